// File: rtl/mem_pkg.sv
// Shared encodings and decode helpers for the MEM-stage load/store engine.
package mem_pkg;

  // mem_op encodings; any other code behaves as OpNone
  localparam logic [3:0] OpNone = 4'd0;
  localparam logic [3:0] OpLb   = 4'd1;
  localparam logic [3:0] OpLbu  = 4'd2;
  localparam logic [3:0] OpLh   = 4'd3;
  localparam logic [3:0] OpLhu  = 4'd4;
  localparam logic [3:0] OpLw   = 4'd5;
  localparam logic [3:0] OpSb   = 4'd8;
  localparam logic [3:0] OpSh   = 4'd9;
  localparam logic [3:0] OpSw   = 4'd10;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDone = 2'd2
  } mem_state_e;

  function automatic logic is_load(input logic [3:0] op);
    return (op == OpLb) || (op == OpLbu) || (op == OpLh) || (op == OpLhu) || (op == OpLw);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == OpSb) || (op == OpSh) || (op == OpSw);
  endfunction

  function automatic logic is_half(input logic [3:0] op);
    return (op == OpLh) || (op == OpLhu) || (op == OpSh);
  endfunction

  function automatic logic is_word(input logic [3:0] op);
    return (op == OpLw) || (op == OpSw);
  endfunction

  // Little-endian byte enables for the access size at low address bits lo
  function automatic logic [3:0] byte_en(input logic [3:0] op, input logic [1:0] lo);
    if (is_word(op)) return 4'b1111;
    if (is_half(op)) return lo[1] ? 4'b1100 : 4'b0011;
    if (is_load(op) || is_store(op)) return 4'b0001 << lo;
    return 4'b0000;
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Selects the addressed byte/halfword lane of read data and sign/zero extends it.
module load_formatter
  import mem_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  lo,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select then extension by load type
  always_comb begin
    byte_v    = 8'(rdata >> {lo, 3'b000});
    half_v    = 16'(rdata >> {lo[1], 4'b0000});
    load_data = rdata;
    case (op)
      OpLb:    load_data = {{24{byte_v[7]}}, byte_v};
      OpLbu:   load_data = {24'h0, byte_v};
      OpLh:    load_data = {{16{half_v[15]}}, half_v};
      OpLhu:   load_data = {16'h0, half_v};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: req/ack data-memory handshake, byte enables,
// store lane replication, load formatting and pipeline stall.
// Optional: define MEM_ADDR_ERR_EN to trap misaligned halfword/word accesses
// (addr_err/bad_vaddr); otherwise misaligned low address bits are masked.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [3:0]    mem_op,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] store_data,
  input  logic          flush,
  output logic          stall,
  output logic          out_valid,
  output logic [DW-1:0] load_data,
  output logic          mem_req,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          addr_err,
  output logic [AW-1:0] bad_vaddr
);

  mem_state_e    state_q, state_d;
  logic [3:0]    op_q;
  logic [1:0]    lo_q;
  logic          drop_q;
  logic [DW-1:0] load_data_q;
  logic          mem_req_q, mem_we_q;
  logic [3:0]    mem_be_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q, wdata_d, fmt_data;
  logic [1:0]    lo_eff;
  logic          misalign, is_mem, issue;

  // Effective low address bits and misalignment detection
  always_comb begin
    is_mem = is_load(mem_op) || is_store(mem_op);
    lo_eff = addr[1:0];
`ifdef MEM_ADDR_ERR_EN
    misalign = (is_half(mem_op) && addr[0]) || (is_word(mem_op) && (addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
    if (is_half(mem_op)) lo_eff = {addr[1], 1'b0};
    if (is_word(mem_op)) lo_eff = 2'b00;
`endif
    issue = (state_q == StIdle) && in_valid && is_mem && !flush && !misalign;
  end

  // Store data lane replication
  always_comb begin
    wdata_d = '0;
    case (mem_op)
      OpSb:    wdata_d = {4{store_data[7:0]}};
      OpSh:    wdata_d = {2{store_data[15:0]}};
      OpSw:    wdata_d = store_data;
      default: wdata_d = '0;
    endcase
  end

  // FSM next state, stall and completion pulse
  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (issue) begin
          stall   = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        stall = 1'b1;
        // A flushed transaction still finishes on the bus but is not reported
        if (mem_ack) state_d = (drop_q || flush) ? StIdle : StDone;
      end
      StDone: begin
        out_valid = !flush;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, bus request registers and load result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= OpNone;
      lo_q        <= 2'b00;
      drop_q      <= 1'b0;
      load_data_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= is_store(mem_op);
        mem_be_q    <= byte_en(mem_op, lo_eff);
        mem_addr_q  <= {addr[AW-1:2], 2'b00};
        mem_wdata_q <= wdata_d;
        op_q        <= mem_op;
        lo_q        <= lo_eff;
        drop_q      <= 1'b0;
      end
      if (state_q == StWait) begin
        if (flush) drop_q <= 1'b1;
        if (mem_ack) begin
          mem_req_q <= 1'b0;
          if (!(drop_q || flush)) load_data_q <= is_store(op_q) ? '0 : fmt_data;
        end
      end
    end
  end

`ifdef MEM_ADDR_ERR_EN
  logic [AW-1:0] bad_vaddr_q;

  assign addr_err = (state_q == StIdle) && in_valid && is_mem && misalign;

  // Capture the faulting address on a misaligned access
  always_ff @(posedge clk) begin
    if (rst) begin
      bad_vaddr_q <= '0;
    end else if (addr_err) begin
      bad_vaddr_q <= addr;
    end
  end

  assign bad_vaddr = bad_vaddr_q;
`else
  assign addr_err  = 1'b0;
  assign bad_vaddr = '0;
`endif

  load_formatter u_fmt (
    .op        (op_q),
    .lo        (lo_q),
    .rdata     (mem_rdata),
    .load_data (fmt_data)
  );

  assign load_data = load_data_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: table of single memory ops with a scoreboard of
// expected load results, plus hand sequences for flush, reset and alignment.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [3:0]  mem_op = OpNone;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic        flush = 1'b0;
  logic        stall, out_valid, mem_req, mem_we, addr_err;
  logic [31:0] load_data, mem_addr, mem_wdata, bad_vaddr;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int          tests = 0;
  int          fails = 0;
  int          mdl_cnt = 0;
  int          mdl_delay = 1;
  logic [31:0] mdl_rdata = '0;
  logic [31:0] exp_q[$];
  logic [31:0] last_ld = '0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rdata;
    int          delay;
    logic        we;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] wdata;
    logic [31:0] ld;
  } vec_t;

  vec_t vecs[$];

  mem_access_unit #(.AW(32), .DW(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .mem_op     (mem_op),
    .addr       (addr),
    .store_data (store_data),
    .flush      (flush),
    .stall      (stall),
    .out_valid  (out_valid),
    .load_data  (load_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .addr_err   (addr_err),
    .bad_vaddr  (bad_vaddr)
  );

  always #5 clk = ~clk;

  // Memory model: ack in the mdl_delay-th cycle that mem_req is high
  always @(negedge clk) begin
    if (mem_req && !rst) begin
      mdl_cnt   = mdl_cnt + 1;
      mem_ack   = (mdl_cnt == mdl_delay);
      mem_rdata = mem_ack ? mdl_rdata : 32'h0;
    end else begin
      mdl_cnt   = 0;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rd, input int dly, input logic we,
                         input logic [3:0] be, input logic [31:0] ma, input logic [31:0] wd,
                         input logic [31:0] ld);
    vec_t v;
    v.op = op; v.addr = a; v.sd = sd; v.rdata = rd; v.delay = dly;
    v.we = we; v.be = be; v.maddr = ma; v.wdata = wd; v.ld = ld;
    vecs.push_back(v);
  endtask

  task automatic run_vec(input vec_t v);
    int    stalls = 0;
    bit    done = 0;
    logic [31:0] exp;
    @(posedge clk); #1;
    mdl_delay = v.delay; mdl_rdata = v.rdata;
    in_valid = 1'b1; mem_op = v.op; addr = v.addr; store_data = v.sd;
    exp_q.push_back(v.ld);
    for (int cyc = 0; cyc < 30 && !done; cyc++) begin
      @(negedge clk);
      if (stall) stalls++;
      if (mem_req) begin
        chk("mem_we", {31'h0, mem_we}, {31'h0, v.we});
        chk("mem_be", {28'h0, mem_be}, {28'h0, v.be});
        chk("mem_addr", mem_addr, v.maddr);
        if (v.we) chk("mem_wdata", mem_wdata, v.wdata);
      end
      if (out_valid) begin
        done = 1;
        exp = exp_q.pop_front();
        chk("load_data", load_data, exp);
        last_ld = exp;
        chk("done_stall", {31'h0, stall}, 32'h0);
      end
    end
    chk("timeout", {31'h0, done}, 32'h1);
    chk("stall_cycles", stalls, v.delay + 1);
    @(posedge clk); #1;
    in_valid = 1'b0; mem_op = OpNone;
    @(negedge clk);
    chk("single_pulse", {31'h0, out_valid}, 32'h0);
    chk("no_reissue", {31'h0, mem_req}, 32'h0);
  endtask

  initial begin
    int ovs, sts;
    // op, addr, sd, rdata, delay, we, be, mem_addr, wdata, load_data
    add_vec(OpLw,  32'h100, 32'h0, 32'hDEADBEEF, 1, 0, 4'b1111, 32'h100, 32'h0, 32'hDEADBEEF);
    add_vec(OpLb,  32'h103, 32'h0, 32'h80FF1234, 1, 0, 4'b1000, 32'h100, 32'h0, 32'hFFFFFF80);
    add_vec(OpLbu, 32'h103, 32'h0, 32'h80FF1234, 1, 0, 4'b1000, 32'h100, 32'h0, 32'h00000080);
    add_vec(OpLh,  32'h102, 32'h0, 32'h80FF1234, 1, 0, 4'b1100, 32'h100, 32'h0, 32'hFFFF80FF);
    add_vec(OpLhu, 32'h100, 32'h0, 32'h80FF9234, 2, 0, 4'b0011, 32'h100, 32'h0, 32'h00009234);
    add_vec(OpSb,  32'h201, 32'hAB, 32'h0, 1, 1, 4'b0010, 32'h200, 32'hABABABAB, 32'h0);
    add_vec(OpSh,  32'h202, 32'h1234, 32'h0, 1, 1, 4'b1100, 32'h200, 32'h12341234, 32'h0);
    add_vec(OpSw,  32'h204, 32'hCAFEF00D, 32'h0, 3, 1, 4'b1111, 32'h204, 32'hCAFEF00D, 32'h0);
    add_vec(OpLb,  32'h101, 32'h0, 32'h00007F00, 2, 0, 4'b0010, 32'h100, 32'h0, 32'h0000007F);
`ifndef MEM_ADDR_ERR_EN
    add_vec(OpSh,  32'h203, 32'h5678, 32'h0, 1, 1, 4'b1100, 32'h200, 32'h56785678, 32'h0);
    add_vec(OpLh,  32'h101, 32'h0, 32'h1234ABCD, 1, 0, 4'b0011, 32'h100, 32'h0, 32'hFFFFABCD);
    add_vec(OpLw,  32'h102, 32'h0, 32'h13579BDF, 1, 0, 4'b1111, 32'h100, 32'h0, 32'h13579BDF);
`endif
    add_vec(OpLw,  32'h300, 32'h0, 32'h01234567, 5, 0, 4'b1111, 32'h300, 32'h0, 32'h01234567);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req", {31'h0, mem_req}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_be", {28'h0, mem_be}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_bad_vaddr", bad_vaddr, 32'h0);
    chk("rst_addr_err", {31'h0, addr_err}, 32'h0);

    foreach (vecs[i]) run_vec(vecs[i]);
    chk("sb_empty", exp_q.size(), 32'h0);

    // Flush during WAIT: bus op completes, no pulse, load_data kept
    @(posedge clk); #1;
    mdl_delay = 3; mdl_rdata = 32'h5555AAAA;
    in_valid = 1'b1; mem_op = OpLw; addr = 32'h400;
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b0; mem_op = OpNone;
    @(posedge clk); #1;
    flush = 1'b0;
    ovs = 0; sts = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) ovs++;
      if (stall) sts++;
    end
    chk("flush_wait_pulse", ovs, 0);
    chk("flush_wait_stall", sts, 2);
    chk("flush_wait_ld", load_data, last_ld);
    chk("flush_wait_req", {31'h0, mem_req}, 32'h0);

    // Flush during DONE: pulse suppressed, result still captured
    @(posedge clk); #1;
    mdl_delay = 1; mdl_rdata = 32'h0BADF00D;
    in_valid = 1'b1; mem_op = OpLw; addr = 32'h500;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b0; mem_op = OpNone;
    @(negedge clk);
    chk("flush_done_pulse", {31'h0, out_valid}, 32'h0);
    chk("flush_done_ld", load_data, 32'h0BADF00D);
    @(posedge clk); #1;
    flush = 1'b0;

    // Flush in IDLE: no issue
    in_valid = 1'b1; mem_op = OpLw; addr = 32'h600; flush = 1'b1;
    @(negedge clk);
    chk("flush_idle_stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; mem_op = OpNone;
    @(negedge clk);
    chk("flush_idle_req", {31'h0, mem_req}, 32'h0);

    // Non-memory op codes do not stall
    in_valid = 1'b1; mem_op = 4'd6; addr = 32'h700;
    @(negedge clk);
    chk("nonmem_stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    in_valid = 1'b0; mem_op = OpNone;
    @(negedge clk);
    chk("nonmem_req", {31'h0, mem_req}, 32'h0);

    // Reset mid-WAIT abandons the transaction
    @(posedge clk); #1;
    mdl_delay = 5; mdl_rdata = 32'h11111111;
    in_valid = 1'b1; mem_op = OpLw; addr = 32'h800;
    @(posedge clk); #1;
    in_valid = 1'b0; mem_op = OpNone;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("pre_rst_stall", {31'h0, stall}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wait_req", {31'h0, mem_req}, 32'h0);
    chk("rst_wait_stall", {31'h0, stall}, 32'h0);
    chk("rst_wait_ld", load_data, 32'h0);

`ifdef MEM_ADDR_ERR_EN
    // Misaligned word access traps instead of issuing
    @(posedge clk); #1;
    in_valid = 1'b1; mem_op = OpLw; addr = 32'h102;
    @(negedge clk);
    chk("ae_flag", {31'h0, addr_err}, 32'h1);
    chk("ae_stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    in_valid = 1'b0; mem_op = OpNone;
    @(negedge clk);
    chk("ae_req", {31'h0, mem_req}, 32'h0);
    chk("ae_bad_vaddr", bad_vaddr, 32'h102);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
